// File: rtl/quad_decoder_ctr.sv
// Quadrature decoder with position counter: two-flop input synchronizers,
// edge decode from (q_prev, q), loadable up/down counter, wrap/step pulses, sticky err.
module quad_decoder_ctr #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             a_in,
  input  logic             b_in,
  input  logic             load,
  input  logic [WIDTH-1:0] l_data,
  input  logic             clr_err,
  output logic [WIDTH-1:0] pos,
  output logic             dir,
  output logic             step,
  output logic             wrap,
  output logic             err
);

  localparam int STAGES = 3;

  logic [1:0]        s1_q, s1_d, s2_q, s2_d;
  logic [1:0]        q, q_prev_q, q_prev_d;
  logic [STAGES-1:0] vld_pipe_q, vld_pipe_d;
  logic [WIDTH-1:0]  pos_q, pos_d;
  logic              dir_q, dir_d;
  logic              step_q, step_d;
  logic              wrap_q, wrap_d;
  logic              err_q, err_d;
  logic              en, mv_up, mv_dn, illegal;

  assign q  = s2_q;
  // Decode waits until the synchronizers and q_prev hold post-reset input,
  // so a static non-zero input at release is never seen as a jump from 00.
  assign en = vld_pipe_q[STAGES-1];

  always_comb begin
    mv_up = 1'b0;
    mv_dn = 1'b0;
    case ({q_prev_q, q})
      4'b0001, 4'b0111, 4'b1110, 4'b1000: mv_up = 1'b1;
      4'b0010, 4'b1011, 4'b1101, 4'b0100: mv_dn = 1'b1;
      default: ;
    endcase
    illegal = ((q_prev_q ^ q) == 2'b11);
  end

  always_comb begin
    s1_d       = {a_in, b_in};
    s2_d       = s1_q;
    q_prev_d   = q;
    vld_pipe_d = {vld_pipe_q[STAGES-2:0], 1'b1};
    pos_d      = pos_q;
    dir_d      = dir_q;
    step_d     = 1'b0;
    wrap_d     = 1'b0;
    err_d      = err_q;
    if (en) begin
      if (clr_err) err_d = 1'b0;
      if (illegal) err_d = 1'b1;
      // load wins over a step; q_prev still advances so the step is consumed
      if (load) begin
        pos_d = l_data;
      end else if (mv_up) begin
        pos_d  = pos_q + WIDTH'(1);
        dir_d  = 1'b1;
        step_d = 1'b1;
        wrap_d = (pos_q == {WIDTH{1'b1}});
      end else if (mv_dn) begin
        pos_d  = pos_q - WIDTH'(1);
        dir_d  = 1'b0;
        step_d = 1'b1;
        wrap_d = (pos_q == '0);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_q       <= '0;
      s2_q       <= '0;
      q_prev_q   <= '0;
      vld_pipe_q <= '0;
      pos_q      <= '0;
      dir_q      <= 1'b0;
      step_q     <= 1'b0;
      wrap_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      s1_q       <= s1_d;
      s2_q       <= s2_d;
      q_prev_q   <= q_prev_d;
      vld_pipe_q <= vld_pipe_d;
      pos_q      <= pos_d;
      dir_q      <= dir_d;
      step_q     <= step_d;
      wrap_q     <= wrap_d;
      err_q      <= err_d;
    end
  end

  assign pos  = pos_q;
  assign dir  = dir_q;
  assign step = step_q;
  assign wrap = wrap_q;
  assign err  = err_q;

endmodule
